// File: rtl/cache_ctrl_pkg.sv
// Shared types and encodings for the 2-way cache controller.
// State enum, way index type and datapath mux select values.
package cache_ctrl_pkg;

  localparam int WAY_W = 1;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    ALLOCATE
  } cache_state_e;

  typedef logic [WAY_W-1:0] way_t;

  localparam logic DATA_SRC_CPU  = 1'b0;
  localparam logic DATA_SRC_PMEM = 1'b1;
  localparam logic ADDR_SRC_CPU  = 1'b0;
  localparam logic ADDR_SRC_WB   = 1'b1;

endpackage

// File: rtl/cache_ctrl_2way.sv
// Control FSM for a 2-way set-associative cache:
// zero-wait hits, dirty writeback and line allocation.
module cache_ctrl_2way
  import cache_ctrl_pkg::*;
#(
  parameter int S_WAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic [1:0]       hit,
  input  logic [S_WAY-1:0] plru_way,
  input  logic [1:0]       victim_dirty,
  output logic             plru_load,
  output logic [S_WAY-1:0] plru_mru,
  output logic [S_WAY-1:0] way_sel,
  output logic             load_data,
  output logic             data_src,
  output logic             load_tag,
  output logic             set_valid,
  output logic             set_dirty,
  output logic             clr_dirty,
  output logic             addr_src,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp
);

  if (S_WAY != 1) begin : g_bad_sway
    $error("cache_ctrl_2way: only S_WAY = 1 is supported");
  end

  cache_state_e     r_state;
  cache_state_e     w_next;
  logic [S_WAY-1:0] r_victim;

  logic             w_req;
  logic             w_hit;
  logic             w_miss;
  logic [S_WAY-1:0] w_hit_way;

  assign w_req     = mem_read | mem_write;
  assign w_hit     = |hit;
  assign w_miss    = w_req & ~w_hit;
  assign w_hit_way = S_WAY'(hit[1]);

  // Victim is frozen for the whole miss so PLRU updates cannot redirect it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= CHECK;
      r_victim <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == CHECK && w_miss) begin
        r_victim <= plru_way;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    mem_resp   = 1'b0;
    plru_load  = 1'b0;
    plru_mru   = '0;
    way_sel    = '0;
    load_data  = 1'b0;
    data_src   = DATA_SRC_CPU;
    load_tag   = 1'b0;
    set_valid  = 1'b0;
    set_dirty  = 1'b0;
    clr_dirty  = 1'b0;
    addr_src   = ADDR_SRC_CPU;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    unique case (r_state)
      CHECK: begin
        if (w_miss) begin
          w_next = victim_dirty[plru_way] ? WRITEBACK : ALLOCATE;
        end
        if (w_req && w_hit && !rst) begin
          mem_resp  = 1'b1;
          plru_load = 1'b1;
          plru_mru  = w_hit_way;
          way_sel   = w_hit_way;
          if (mem_write) begin
            load_data = 1'b1;
            data_src  = DATA_SRC_CPU;
            set_dirty = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        way_sel    = r_victim;
        addr_src   = ADDR_SRC_WB;
        pmem_write = 1'b1;
        if (pmem_resp) begin
          w_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        way_sel   = r_victim;
        addr_src  = ADDR_SRC_CPU;
        pmem_read = 1'b1;
        if (pmem_resp) begin
          w_next = CHECK;
          if (!rst) begin
            load_data = 1'b1;
            data_src  = DATA_SRC_PMEM;
            load_tag  = 1'b1;
            set_valid = 1'b1;
            clr_dirty = 1'b1;
          end
        end
      end
      default: w_next = CHECK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(mem_read && mem_write))
        else $error("cache_ctrl_2way: read and write requested together");
      assert (!(r_state == CHECK && w_req && hit == 2'b11))
        else $error("cache_ctrl_2way: hit reported in both ways");
    end
  end

endmodule
